// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and constants for the data-RAM access sequencer.
// The controller state machine and the requester-ownership tag live here.
package ram_access_ctrl_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [LANES-1:0] BE_FULL = '1;
  localparam logic [LANES-1:0] BE_NONE = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WAIT,
    ST_RMW_WR
  } rac_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } rac_owner_t;

  // Classifies a store by its byte enables: full word, nothing, or sub-word.
  function automatic logic be_is_partial(logic [LANES-1:0] be);
    return (be != BE_FULL) && (be != BE_NONE);
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Requester and RAM-side bus of the data-RAM sequencer.
// slave = the controller; master = the core stages plus the RAM macro.
interface ram_access_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                      if_req_in;
  logic [ADDR_WIDTH-1:0]     if_addr_in;
  logic [DATA_WIDTH-1:0]     if_rdata_out;
  logic                      if_ack_out;

  logic                      mem_req_in;
  logic                      mem_we_in;
  logic [ADDR_WIDTH-1:0]     mem_addr_in;
  logic [DATA_WIDTH-1:0]     mem_wdata_in;
  logic [DATA_WIDTH/8-1:0]   mem_be_in;
  logic [DATA_WIDTH-1:0]     mem_rdata_out;
  logic                      mem_ack_out;

  logic                      ram_ce_out;
  logic                      ram_we_out;
  logic [ADDR_WIDTH-1:0]     ram_addr_out;
  logic [DATA_WIDTH-1:0]     ram_wdata_out;
  logic [DATA_WIDTH-1:0]     ram_rdata_in;

  logic                      busy_out;

  modport slave (
    input  if_req_in, if_addr_in,
    input  mem_req_in, mem_we_in, mem_addr_in, mem_wdata_in, mem_be_in,
    input  ram_rdata_in,
    output if_rdata_out, if_ack_out,
    output mem_rdata_out, mem_ack_out,
    output ram_ce_out, ram_we_out, ram_addr_out, ram_wdata_out,
    output busy_out
  );

  modport master (
    output if_req_in, if_addr_in,
    output mem_req_in, mem_we_in, mem_addr_in, mem_wdata_in, mem_be_in,
    output ram_rdata_in,
    input  if_rdata_out, if_ack_out,
    input  mem_rdata_out, mem_ack_out,
    input  ram_ce_out, ram_we_out, ram_addr_out, ram_wdata_out,
    input  busy_out
  );

endinterface

// File: rtl/ram_access_ctrl_byte_merge.sv
// Combinational byte-lane merge: enabled lanes take the new word, others keep the old.
// Also intended for the cache line-fill path.
module ram_byte_merge #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH/8-1:0] be_in,
  input  logic [DATA_WIDTH-1:0]   new_in,
  input  logic [DATA_WIDTH-1:0]   old_in,
  output logic [DATA_WIDTH-1:0]   merged_out
);

  for (genvar g = 0; g < DATA_WIDTH / 8; g++) begin : g_lane
    assign merged_out[8*g +: 8] = be_in[g] ? new_in[8*g +: 8] : old_in[8*g +: 8];
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequencer/arbiter for the single-port data RAM shared by fetch and the MEM stage.
// Sub-word stores become read-merge-write sequences; one requester is served at a time.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IF_STARVE_MAX = 4
) (
  input logic              clk_in,
  input logic              reset_n_in,
  ram_access_ctrl_if.slave bus
);

  localparam int unsigned CW = (IF_STARVE_MAX < 1) ? 1 : $clog2(IF_STARVE_MAX + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

  rac_state_t              state_q, state_d;
  rac_owner_t              owner_q, owner_d;
  logic [LANES-1:0]        be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]           starve_q, starve_d;

  logic                    ce_q, ce_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0]   rwdata_q, rwdata_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic                    if_ack_q, if_ack_d;
  logic [DATA_WIDTH-1:0]   mem_rdata_q, mem_rdata_d;
  logic                    mem_ack_q, mem_ack_d;

  logic                    if_forced;
  logic                    grant_mem;
  logic                    grant_if;
  logic [DATA_WIDTH-1:0]   merged;

  ram_byte_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_merge (
    .be_in      (be_q),
    .new_in     (wdata_q),
    .old_in     (bus.ram_rdata_in),
    .merged_out (merged)
  );

  assign if_forced = (starve_q == CW'(IF_STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    starve_d    = starve_q;
    ce_d        = 1'b0;
    we_d        = 1'b0;
    raddr_d     = raddr_q;
    rwdata_d    = rwdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    grant_mem   = 1'b0;
    grant_if    = 1'b0;

    // The ack cycle sits in IDLE but must not grant, so the next grant lands after it.
    if ((state_q == ST_IDLE) && !(if_ack_q || mem_ack_q)) begin
      grant_mem = bus.mem_req_in && !(bus.if_req_in && if_forced);
      grant_if  = bus.if_req_in && !grant_mem;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_mem) begin
          owner_d = OWN_MEM;
          be_d    = bus.mem_be_in;
          wdata_d = bus.mem_wdata_in;
          if (!bus.mem_we_in) begin
            state_d = ST_RD;
            ce_d    = 1'b1;
            raddr_d = bus.mem_addr_in & ADDR_MASK;
          end else if (bus.mem_be_in == BE_FULL) begin
            state_d  = ST_WR;
            ce_d     = 1'b1;
            we_d     = 1'b1;
            raddr_d  = bus.mem_addr_in & ADDR_MASK;
            rwdata_d = bus.mem_wdata_in;
          end else if (be_is_partial(bus.mem_be_in)) begin
            state_d = ST_RMW_RD;
            ce_d    = 1'b1;
            raddr_d = bus.mem_addr_in & ADDR_MASK;
          end else begin
            mem_ack_d = 1'b1;
          end
        end else if (grant_if) begin
          owner_d = OWN_IF;
          state_d = ST_RD;
          ce_d    = 1'b1;
          raddr_d = bus.if_addr_in & ADDR_MASK;
        end
      end
      ST_RD: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_d = ST_IDLE;
        if (owner_q == OWN_IF) begin
          if_rdata_d = bus.ram_rdata_in;
          if_ack_d   = 1'b1;
        end else begin
          mem_rdata_d = bus.ram_rdata_in;
          mem_ack_d   = 1'b1;
        end
      end
      ST_WR: begin
        state_d   = ST_IDLE;
        mem_ack_d = 1'b1;
      end
      ST_RMW_RD: begin
        state_d = ST_RMW_WAIT;
      end
      ST_RMW_WAIT: begin
        state_d  = ST_RMW_WR;
        ce_d     = 1'b1;
        we_d     = 1'b1;
        rwdata_d = merged;
      end
      ST_RMW_WR: begin
        state_d   = ST_IDLE;
        mem_ack_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!bus.if_req_in || grant_if) begin
      starve_d = '0;
    end else if (grant_mem && !if_forced) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      be_q        <= '0;
      wdata_q     <= '0;
      starve_q    <= '0;
      ce_q        <= 1'b0;
      we_q        <= 1'b0;
      raddr_q     <= '0;
      rwdata_q    <= '0;
      if_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      mem_rdata_q <= '0;
      mem_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      starve_q    <= starve_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      raddr_q     <= raddr_d;
      rwdata_q    <= rwdata_d;
      if_rdata_q  <= if_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ack_q   <= mem_ack_d;
    end
  end

  assign bus.ram_ce_out    = ce_q;
  assign bus.ram_we_out    = we_q;
  assign bus.ram_addr_out  = raddr_q;
  assign bus.ram_wdata_out = rwdata_q;
  assign bus.if_rdata_out  = if_rdata_q;
  assign bus.if_ack_out    = if_ack_q;
  assign bus.mem_rdata_out = mem_rdata_q;
  assign bus.mem_ack_out   = mem_ack_q;
  assign bus.busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomized bench for ram_access_ctrl: a bus-level RAM, a word-level reference memory,
// and a grant-order model derived from the starvation rule.
module tb_ram_access_ctrl;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_access_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ram_access_ctrl #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .IF_STARVE_MAX (4)
  ) dut (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ram_rdata_r;
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  int unsigned rd_cnt = 0, wr_cnt = 0, addr_bad = 0, pulse_bad = 0;
  logic        prev_if_ack = 1'b0, prev_mem_ack = 1'b0;
  logic [29:0] exp_word;
  bit          addr_chk_en;

  logic [31:0] last_if_rdata, last_mem_rdata;
  int unsigned starve_m;

  assign bus.ram_rdata_in = ram_rdata_r;

  // RAM macro: synchronous, read data valid the cycle after a read; garbage otherwise.
  always @(posedge clk) begin
    if (pre_we) ram[pre_idx] <= pre_val;
    if (bus.ram_ce_out && bus.ram_we_out) ram[bus.ram_addr_out[9:2]] <= bus.ram_wdata_out;
    if (bus.ram_ce_out && !bus.ram_we_out) ram_rdata_r <= ram[bus.ram_addr_out[9:2]];
    else ram_rdata_r <= $urandom;
  end

  always @(posedge clk) begin
    if (bus.ram_ce_out) begin
      if (bus.ram_we_out) wr_cnt <= wr_cnt + 1;
      else rd_cnt <= rd_cnt + 1;
      if (addr_chk_en && (bus.ram_addr_out !== {exp_word, 2'b00})) addr_bad <= addr_bad + 1;
    end
    if ((bus.if_ack_out && prev_if_ack) || (bus.mem_ack_out && prev_mem_ack))
      pulse_bad <= pulse_bad + 1;
    prev_if_ack  <= bus.if_ack_out;
    prev_mem_ack <= bus.mem_ack_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge_word(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) if (be[i]) mask[8*i +: 8] = 8'hFF;
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Grant-order model: MEM preferred unless IF has already waited IF_STARVE_MAX MEM grants.
  task automatic arb_decide(input bit ifr, input bit memr, output bit is_if);
    if (!ifr) starve_m = 0;
    if (memr && !(ifr && starve_m == 4)) begin
      is_if = 1'b0;
      if (ifr) starve_m = starve_m + 1;
    end else begin
      is_if = 1'b1;
      starve_m = 0;
    end
  endtask

  // kind: 0 fetch, 1 load, 2 full store, 3 partial store, 4 empty store
  task automatic run_txn(input int unsigned kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit b2b);
    int unsigned rd0, wr0, ab0, lat, other, exp_lat, exp_rd, exp_wr;
    bit          got, is_if;
    logic [7:0]  idx;
    logic [31:0] expv;
    rd0 = rd_cnt; wr0 = wr_cnt; ab0 = addr_bad;
    idx = addr[9:2];
    exp_word = addr[31:2];
    is_if = (kind == 0);
    case (kind)
      0, 1:    begin exp_lat = 3; exp_rd = 1; exp_wr = 0; end
      2:       begin exp_lat = 2; exp_rd = 0; exp_wr = 1; end
      3:       begin exp_lat = 4; exp_rd = 1; exp_wr = 1; end
      default: begin exp_lat = 1; exp_rd = 0; exp_wr = 0; end
    endcase
    if (b2b) exp_lat = exp_lat + 1;
    if (is_if) begin
      bus.mem_req_in = 1'b0;
      bus.if_addr_in = addr;
      bus.if_req_in  = 1'b1;
    end else begin
      bus.if_req_in    = 1'b0;
      bus.mem_we_in    = (kind != 1);
      bus.mem_addr_in  = addr;
      bus.mem_wdata_in = wdata;
      bus.mem_be_in    = be;
      bus.mem_req_in   = 1'b1;
    end
    lat = 0; got = 1'b0; other = 0;
    while (!got && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (is_if ? bus.if_ack_out : bus.mem_ack_out) got = 1'b1;
      if (is_if ? bus.mem_ack_out : bus.if_ack_out) other++;
    end
    chk("latency", lat, exp_lat);
    chk("other_ack", other, 0);
    chk("ram_reads", rd_cnt - rd0, exp_rd);
    chk("ram_writes", wr_cnt - wr0, exp_wr);
    chk("ram_addr", addr_bad - ab0, 0);
    chk("busy_at_ack", {31'b0, bus.busy_out}, 0);
    if (is_if) begin
      expv = ref_mem[idx];
      chk("if_rdata", bus.if_rdata_out, expv);
      chk("mem_rdata_hold", bus.mem_rdata_out, last_mem_rdata);
      last_if_rdata = expv;
    end else if (kind == 1) begin
      expv = ref_mem[idx];
      chk("mem_rdata", bus.mem_rdata_out, expv);
      chk("if_rdata_hold", bus.if_rdata_out, last_if_rdata);
      last_mem_rdata = expv;
    end else begin
      ref_mem[idx] = merge_word(ref_mem[idx], wdata, (kind == 2) ? 4'hF : be);
      chk("ram_word", ram[idx], ref_mem[idx]);
      chk("mem_rdata_hold", bus.mem_rdata_out, last_mem_rdata);
      chk("if_rdata_hold", bus.if_rdata_out, last_if_rdata);
    end
  endtask

  initial begin
    int unsigned if_acks, mem_acks, cyc, kind;
    bit          pred_if, b2b;
    logic [31:0] a, w, ia, ma, v;
    logic [3:0]  be;
    logic [7:0]  ridx;
    int unsigned wr0;

    rst_n = 1'b0;
    bus.if_req_in = 1'b0; bus.if_addr_in = '0;
    bus.mem_req_in = 1'b0; bus.mem_we_in = 1'b0; bus.mem_addr_in = '0;
    bus.mem_wdata_in = '0; bus.mem_be_in = '0;
    addr_chk_en = 1'b1; exp_word = '0;
    last_if_rdata = '0; last_mem_rdata = '0; starve_m = 0;
    pre_we = 1'b1; pre_idx = '0; pre_val = '0;

    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      if (i == 'h40) v = 32'hDEADBEEF;
      else if (i == 'h42) v = 32'hAABBCCDD;
      else v = $urandom;
      pre_idx = i[7:0]; pre_val = v; ref_mem[i] = v;
      @(negedge clk);
    end
    pre_we = 1'b0;

    chk("rst_ce", {31'b0, bus.ram_ce_out}, 0);
    chk("rst_we", {31'b0, bus.ram_we_out}, 0);
    chk("rst_addr", bus.ram_addr_out, 0);
    chk("rst_wdata", bus.ram_wdata_out, 0);
    chk("rst_acks", {30'b0, bus.if_ack_out, bus.mem_ack_out}, 0);
    chk("rst_busy", {31'b0, bus.busy_out}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(1, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
    chk("load_deadbeef", bus.mem_rdata_out, 32'hDEADBEEF);
    bus.mem_req_in = 1'b0; @(negedge clk);
    run_txn(2, 32'h0000_0104, 32'h12345678, 4'hF, 1'b0);
    chk("sw_word", ram['h41], 32'h12345678);
    bus.mem_req_in = 1'b0; @(negedge clk);
    run_txn(3, 32'h0000_0108, 32'h00EE0000, 4'b0100, 1'b0);
    chk("sb_lane2", ram['h42], 32'hAAEECCDD);
    bus.mem_req_in = 1'b0; @(negedge clk);
    run_txn(4, 32'h0000_010C, 32'hFFFFFFFF, 4'b0000, 1'b0);
    run_txn(1, 32'h0000_0108, 32'h0, 4'h0, 1'b1);

    // Contention: both requesters hold requests; grant order follows the starvation rule.
    bus.mem_req_in = 1'b0; bus.if_req_in = 1'b0;
    repeat (2) @(negedge clk);
    addr_chk_en = 1'b0; starve_m = 0;
    if_acks = 0; mem_acks = 0; cyc = 0;
    ia = $urandom; ma = $urandom;
    bus.mem_we_in = 1'b0; bus.mem_addr_in = ma; bus.if_addr_in = ia;
    bus.if_req_in = 1'b1; bus.mem_req_in = 1'b1;
    arb_decide(1'b1, 1'b1, pred_if);
    while (if_acks < 2 && cyc < 300) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (bus.if_ack_out || bus.mem_ack_out) begin
        chk("arb_owner_is_if", {31'b0, bus.if_ack_out}, {31'b0, pred_if});
        if (bus.if_ack_out) begin
          chk("arb_if_rdata", bus.if_rdata_out, ref_mem[ia[9:2]]);
          last_if_rdata = ref_mem[ia[9:2]];
          if_acks++;
          ia = $urandom; bus.if_addr_in = ia;
        end else begin
          chk("arb_mem_rdata", bus.mem_rdata_out, ref_mem[ma[9:2]]);
          last_mem_rdata = ref_mem[ma[9:2]];
          mem_acks++;
          ma = $urandom; bus.mem_addr_in = ma;
        end
        if (if_acks < 2) arb_decide(1'b1, 1'b1, pred_if);
      end
    end
    bus.if_req_in = 1'b0; bus.mem_req_in = 1'b0;
    chk("arb_if_acks", if_acks, 2);
    chk("arb_mem_acks", mem_acks, 8);
    addr_chk_en = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 4);
      a = $urandom; w = $urandom;
      be = (kind == 3) ? 4'($urandom_range(1, 14)) : ((kind == 2) ? 4'hF : 4'h0);
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) begin
        bus.if_req_in = 1'b0; bus.mem_req_in = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      run_txn(kind, a, w, be, b2b);
    end
    bus.if_req_in = 1'b0; bus.mem_req_in = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted while the partial store waits for its read data.
    a = 32'h0000_0230; ridx = a[9:2]; wr0 = wr_cnt;
    exp_word = a[31:2];
    bus.mem_we_in = 1'b1; bus.mem_addr_in = a; bus.mem_wdata_in = 32'h5500_0000;
    bus.mem_be_in = 4'b1000; bus.mem_req_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ce", {31'b0, bus.ram_ce_out}, 0);
    chk("arst_we", {31'b0, bus.ram_we_out}, 0);
    chk("arst_addr", bus.ram_addr_out, 0);
    chk("arst_wdata", bus.ram_wdata_out, 0);
    chk("arst_rdata", bus.mem_rdata_out | bus.if_rdata_out, 0);
    chk("arst_busy", {31'b0, bus.busy_out}, 0);
    @(negedge clk);
    bus.mem_req_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_no_write", wr_cnt - wr0, 0);
    chk("arst_ram_word", ram[ridx], ref_mem[ridx]);
    rst_n = 1'b1;
    last_if_rdata = '0; last_mem_rdata = '0;
    @(negedge clk);
    chk("arst_idle", {31'b0, bus.busy_out}, 0);
    run_txn(1, a, 32'h0, 4'h0, 1'b0);
    bus.mem_req_in = 1'b0;
    repeat (2) @(negedge clk);

    chk("ack_pulse_width", pulse_bad, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
